// File: rtl/pll_freq_meter.sv
// Frequency meter for the PLL output clocks: each clock runs a free counter in its own
// domain, the gray copy is synchronised into clk100 and differenced over a fixed gate window.
module pll_freq_meter #(
  parameter int N_CLK       = 6,
  parameter int CNT_W       = 24,
  parameter int GATE_CYCLES = 100000
) (
  input  logic                   clk100,
  input  logic                   rst,
  input  logic                   i_locked,
  input  logic [N_CLK-1:0]       i_clk,
  output logic [N_CLK*CNT_W-1:0] o_count,
  output logic                   o_valid,
  output logic [7:0]             o_seq,
  output logic                   o_lock_lost,
  output logic [1:0]             o_state
);
  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam int ALL_W = N_CLK * CNT_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRIME   = 2'd1,
    ST_MEASURE = 2'd2
  } state_t;

  logic [ALL_W-1:0] gray_all;

  for (genvar i = 0; i < N_CLK; i++) begin : g_dom
    logic [1:0]       rst_sync_q;
    logic [1:0]       rst_sync_d;
    logic             dom_rst;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] gray_q, gray_d;

    always_comb begin
      rst_sync_d = {rst_sync_q[0], 1'b1};
      cnt_d      = cnt_q + CNT_W'(1);
      gray_d     = cnt_q ^ (cnt_q >> 1);
    end

    always_ff @(posedge i_clk[i] or posedge rst) begin
      if (rst) rst_sync_q <= '0;
      else     rst_sync_q <= rst_sync_d;
    end

    // Asserts with rst immediately, releases only after two local clock edges.
    assign dom_rst = ~rst_sync_q[1];

    always_ff @(posedge i_clk[i] or posedge dom_rst) begin
      if (dom_rst) begin
        cnt_q  <= '0;
        gray_q <= '0;
      end else begin
        cnt_q  <= cnt_d;
        gray_q <= gray_d;
      end
    end

    assign gray_all[i*CNT_W +: CNT_W] = gray_q;
  end

  function automatic logic [CNT_W-1:0] gray2bin(input logic [CNT_W-1:0] g);
    logic [CNT_W-1:0] b;
    for (int k = 0; k < CNT_W; k++) b[k] = ^(g >> k);
    return b;
  endfunction

  logic [ALL_W-1:0] gs1_q, gs2_q, synced;
  logic             lock_s1_q, lock_s2_q;

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      gs1_q     <= '0;
      gs2_q     <= '0;
      lock_s1_q <= 1'b0;
      lock_s2_q <= 1'b0;
    end else begin
      gs1_q     <= gray_all;
      gs2_q     <= gs1_q;
      lock_s1_q <= i_locked;
      lock_s2_q <= lock_s1_q;
    end
  end

  always_comb begin
    synced = '0;
    for (int i = 0; i < N_CLK; i++)
      synced[i*CNT_W +: CNT_W] = gray2bin(gs2_q[i*CNT_W +: CNT_W]);
  end

  state_t           state_q, state_d;
  logic [GATE_W-1:0] gate_q, gate_d, gate_nxt;
  logic             gate_end;
  logic [ALL_W-1:0] prev_q, prev_d;
  logic [ALL_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic [7:0]       seq_q, seq_d;
  logic             lost_q, lost_d;

  always_comb begin
    state_d  = state_q;
    gate_d   = gate_q;
    prev_d   = prev_q;
    count_d  = count_q;
    valid_d  = 1'b0;
    seq_d    = seq_q;
    lost_d   = 1'b0;
    gate_end = (gate_q == GATE_LAST);
    gate_nxt = gate_end ? '0 : gate_q + GATE_W'(1);
    case (state_q)
      ST_IDLE: begin
        gate_d = '0;
        if (lock_s2_q) state_d = ST_PRIME;
      end
      ST_PRIME: begin
        if (!lock_s2_q) begin
          state_d = ST_IDLE;
          gate_d  = '0;
          lost_d  = 1'b1;
        end else begin
          gate_d = gate_nxt;
          if (gate_end) begin
            prev_d  = synced;
            state_d = ST_MEASURE;
          end
        end
      end
      ST_MEASURE: begin
        // Lock loss takes priority over a coinciding window end.
        if (!lock_s2_q) begin
          state_d = ST_IDLE;
          gate_d  = '0;
          lost_d  = 1'b1;
        end else begin
          gate_d = gate_nxt;
          if (gate_end) begin
            for (int i = 0; i < N_CLK; i++)
              count_d[i*CNT_W +: CNT_W] = synced[i*CNT_W +: CNT_W] - prev_q[i*CNT_W +: CNT_W];
            prev_d  = synced;
            valid_d = 1'b1;
            seq_d   = seq_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        gate_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gate_q  <= '0;
      prev_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      seq_q   <= '0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      prev_q  <= prev_d;
      count_q <= count_d;
      valid_q <= valid_d;
      seq_q   <= seq_d;
      lost_q  <= lost_d;
    end
  end

  assign o_count     = count_q;
  assign o_valid     = valid_q;
  assign o_seq       = seq_q;
  assign o_lock_lost = lost_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_pll_freq_meter.sv
// Directed bench for pll_freq_meter: six ratio clocks on a short-gate instance plus a
// narrow-counter instance fed with 250 MHz to exercise counter wrap.
`timescale 1ns/100ps
module tb_pll_freq_meter;
  localparam int N     = 6;
  localparam int W     = 24;
  localparam int GATE  = 1000;
  localparam int ALL_W = N * W;

  logic clk100 = 1'b0;
  logic rst, locked, lock_small;
  logic c0 = 1'b0, c1 = 1'b0, c2 = 1'b0, c3 = 1'b0, c4 = 1'b0, c5 = 1'b0, clk250 = 1'b0;
  logic [N-1:0] clk_en;
  logic [N-1:0] i_clk;
  logic [ALL_W-1:0] o_count;
  logic o_valid, o_lock_lost;
  logic [7:0] o_seq;
  logic [1:0] o_state;
  logic [7:0] o_count_s;
  logic o_valid_s, o_lock_lost_s;
  logic [7:0] o_seq_s;
  logic [1:0] o_state_s;

  always #5 clk100 = ~clk100;
  initial begin #1.3; forever #10 c0 = ~c0; end
  initial begin #2.1; forever #20 c1 = ~c1; end
  initial begin #2.7; forever #30 c2 = ~c2; end
  initial begin #3.4; forever #40 c3 = ~c3; end
  initial begin #4.2; forever #50 c4 = ~c4; end
  initial begin #1.7; forever #60 c5 = ~c5; end
  initial begin #0.5; forever #2 clk250 = ~clk250; end
  assign i_clk = {c5, c4, c3, c2, c1, c0} & clk_en;

  pll_freq_meter #(.N_CLK(N), .CNT_W(W), .GATE_CYCLES(GATE)) dut (
    .clk100(clk100), .rst(rst), .i_locked(locked), .i_clk(i_clk),
    .o_count(o_count), .o_valid(o_valid), .o_seq(o_seq),
    .o_lock_lost(o_lock_lost), .o_state(o_state)
  );

  pll_freq_meter #(.N_CLK(1), .CNT_W(8), .GATE_CYCLES(100)) dut_s (
    .clk100(clk100), .rst(rst), .i_locked(lock_small), .i_clk(clk250),
    .o_count(o_count_s), .o_valid(o_valid_s), .o_seq(o_seq_s),
    .o_lock_lost(o_lock_lost_s), .o_state(o_state_s)
  );

  int checks = 0, failures = 0;
  int cyc = 0;
  int n_valid = 0, n_valid_s = 0, n_lost = 0;
  int last_valid_cyc = -1, first_cyc = 0, lock_cyc = 0;
  int per_ns[N] = '{20, 40, 60, 80, 100, 120};
  logic [7:0] exp_q[$];

  always @(posedge clk100) cyc++;

  task automatic chk(input string tag, input logic [ALL_W-1:0] obs, input logic [ALL_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_true(input string tag, input logic cond, input int info);
    checks++;
    assert (cond === 1'b1) else begin
      failures++;
      $error("FAIL %s observed=%0d", tag, info);
    end
  endtask

  // Within one count of the ideal edge count per * count ~= GATE * 10 ns.
  task automatic chk_cnt(input int idx, input logic [W-1:0] obs, input int per);
    longint err;
    logic ok;
    if (per == 0) ok = (obs == '0);
    else begin
      err = longint'(obs) * per - longint'(GATE) * 10;
      if (err < 0) err = -err;
      ok = (err <= per);
    end
    checks++;
    assert (ok === 1'b1) else begin
      failures++;
      $error("FAIL count[%0d] observed=%0d expected=%0d/%0d ns (+-1)", idx, obs, GATE * 10, per);
    end
  endtask

  task automatic chk_all_counts();
    for (int i = 0; i < N; i++) chk_cnt(i, o_count[i*W +: W], per_ns[i]);
  endtask

  task automatic wait_valids(input int target, input int budget);
    int t = 0;
    while (n_valid < target && t < budget) begin
      @(negedge clk100);
      t++;
    end
    chk_true("valid_timeout", n_valid >= target, n_valid);
  endtask

  always @(negedge clk100) begin
    if (o_lock_lost === 1'b1) n_lost++;
    if (o_valid === 1'b1) begin
      n_valid++;
      chk_true("valid_expected", exp_q.size() > 0, n_valid);
      if (exp_q.size() > 0) chk("seq", o_seq, exp_q.pop_front());
      chk_all_counts();
      if (last_valid_cyc >= 0) chk("valid_interval", cyc - last_valid_cyc, GATE);
      else first_cyc = cyc;
      last_valid_cyc = cyc;
    end
    if (o_valid_s === 1'b1) begin
      n_valid_s++;
      chk_true("wrap_count", o_count_s >= 8'd249 && o_count_s <= 8'd251, o_count_s);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; locked = 1'b0; lock_small = 1'b0; clk_en = '1;
    repeat (5) @(negedge clk100);
    chk("rst_count", o_count, '0);
    chk("rst_valid", o_valid, 0);
    chk("rst_seq", o_seq, 0);
    chk("rst_lost", o_lock_lost, 0);
    chk("rst_state", o_state, 0);
    rst = 1'b0;
    lock_small = 1'b1;

    // No lock for five windows: nothing may happen.
    repeat (5 * GATE) @(negedge clk100);
    chk("unlocked_valids", n_valid, 0);
    chk("unlocked_seq", o_seq, 0);
    chk("unlocked_state", o_state, 0);

    // Lock: PRIME window, then back-to-back results.
    exp_q.push_back(8'd1);
    exp_q.push_back(8'd2);
    lock_cyc = cyc;
    locked = 1'b1;
    wait_valids(1, 3 * GATE);
    chk_true("first_latency", (first_cyc - lock_cyc) >= 2001 && (first_cyc - lock_cyc) <= 2006,
             first_cyc - lock_cyc);
    wait_valids(2, 2 * GATE);

    // Lock drop half way through window 3.
    repeat (GATE / 2) @(negedge clk100);
    locked = 1'b0;
    for (int t = 0; t < 10 && n_lost == 0; t++) @(negedge clk100);
    chk("lost_pulse", n_lost, 1);
    repeat (GATE + 200) @(negedge clk100);
    chk("lost_single", n_lost, 1);
    chk("lost_no_valid", n_valid, 2);
    chk("lost_seq_hold", o_seq, 2);
    chk("lost_state", o_state, 0);
    chk_all_counts();

    // Relock with clock 3 stopped.
    clk_en[3] = 1'b0;
    per_ns[3] = 0;
    exp_q.push_back(8'd3);
    exp_q.push_back(8'd4);
    last_valid_cyc = -1;
    lock_cyc = cyc;
    locked = 1'b1;
    wait_valids(3, 3 * GATE);
    chk_true("relock_latency", (first_cyc - lock_cyc) >= 2001 && (first_cyc - lock_cyc) <= 2006,
             first_cyc - lock_cyc);
    wait_valids(4, 2 * GATE);

    // Asynchronous reset off the clock edge in mid-window.
    repeat (300) @(negedge clk100);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", o_count, '0);
    chk("arst_valid", o_valid, 0);
    chk("arst_seq", o_seq, 0);
    chk("arst_lost", o_lock_lost, 0);
    chk("arst_state", o_state, 0);
    chk("arst_count_small", o_count_s, 0);
    clk_en[3] = 1'b1;
    per_ns[3] = 80;
    last_valid_cyc = -1;
    repeat (5) @(negedge clk100);
    exp_q.push_back(8'd1);
    lock_cyc = cyc;
    rst = 1'b0;
    wait_valids(5, 3 * GATE);
    chk_true("post_rst_latency", (first_cyc - lock_cyc) >= 2001 && (first_cyc - lock_cyc) <= 2006,
             first_cyc - lock_cyc);

    repeat (50) @(negedge clk100);
    chk("queue_drained", exp_q.size(), 0);
    chk("lost_total", n_lost, 1);
    chk_true("wrap_windows", n_valid_s >= 50, n_valid_s);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pll_freq_meter.md
Name: pll_freq_meter

Overview:
- Consumes the six PLLE2_ADV CLKOUT clocks and the PLL LOCKED flag.
- Measures each clock's frequency against the 100 MHz board clock over a fixed gate window.
- Publishes per-clock edge counts for readout and self-check on hardware.
- Sits directly downstream of the PLL test block and replaces the free-running LED divider counters as the observable output.

Parameters:
- N_CLK, 6: number of measured clocks.
- CNT_W, 24: width of per-clock counters and results. The build must satisfy f_max * GATE_CYCLES / 100e6 < 2^CNT_W.
- GATE_CYCLES, 100000: gate window length in clk100 cycles (1 ms).

Ports:
- clk100  in  1  reference/system clock, 100 MHz.
- rst  in  1  reset; asynchronous, active-high. Clock is clk100.
- i_locked  in  1  PLL LOCKED; asynchronous to clk100.
- i_clk  in  N_CLK  measured clocks, each in its own domain.
- o_count  out  N_CLK*CNT_W  edges counted in the last window; clock i occupies bits [i*CNT_W +: CNT_W].
- o_valid  out  1  one-cycle pulse when o_count has just been updated.
- o_seq  out  8  completed-window sequence number; wraps 255->0.
- o_lock_lost  out  1  one-cycle pulse when lock drops during PRIME or MEASURE.

Behaviour:
- Reset: rst asserted asynchronously clears all state in clk100 and in every i_clk domain. After reset: o_count=0, o_valid=0, o_seq=0, o_lock_lost=0, state=IDLE.
- Per-clock counter, i_clk[i] domain:
  - Free-running CNT_W-bit binary counter, incremented every rising edge.
  - Registered gray copy; binary-to-gray conversion is registered, so only gray crosses domains.
  - rst resets these flops asynchronously. Deassertion is synchronised into each i_clk domain with a 2-flop reset synchroniser.
- CDC into clk100:
  - Each gray bus passes through a 2-flop synchroniser, then gray->binary conversion.
  - i_locked passes through its own 2-flop synchroniser, giving locked_s.
- Gate counter: clog2(GATE_CYCLES) bits; counts 0..GATE_CYCLES-1 and wraps. A window ends on the cycle the count equals GATE_CYCLES-1 (gate_end).
- State machine, clk100:
  - IDLE: gate counter held at 0. When locked_s=1, go to PRIME.
  - PRIME: gate counter runs. On gate_end, snapshot all synced counts into prev[i], emit no output, go to MEASURE.
  - MEASURE: on each gate_end:
    - diff[i] = synced[i] - prev[i], modulo 2^CNT_W; wrap-around is handled by the modular subtract.
    - prev[i] <= synced[i].
    - Next cycle: o_count <= diff, o_valid=1 for one cycle, o_seq increments.
  - Lock loss: locked_s=0 in PRIME or MEASURE forces IDLE on the next cycle.
    - o_lock_lost pulses for one cycle.
    - The in-progress window is discarded; no o_valid for it.
    - o_count and o_seq retain their values.
  - Simultaneous lock loss and gate_end: lock loss wins; no o_valid.
- Latency: o_valid is asserted exactly 1 clk100 cycle after gate_end. Windows are back-to-back with no dead cycles, so one o_valid occurs every GATE_CYCLES cycles.
- Accuracy: synchroniser delay is identical at both window edges and cancels. Each result is within ±1 of f_i * GATE_CYCLES / 100e6.
- A stopped clock yields diff=0 with no error.

Test Plan:
1. Bench drives i_clk = 50, 25, 16.667, 12.5, 10, 8.333 MHz and raises i_locked at t=2 µs. Required:
   - First o_valid about 2 windows later.
   - o_count = 50000, 25000, 16666/16667, 12500, 10000, 8333/8334 (each ±1).
   - o_seq = 1.
   - Then one o_valid every 100000 cycles.
2. i_locked held low for 5 windows -> no o_valid, o_seq stays 0, state stays IDLE.
3. i_locked drops mid-MEASURE at window 3:
   - o_lock_lost pulses once and no o_valid occurs for that window.
   - o_count holds window-2 values.
   - After relock, the PRIME window produces no output, then o_seq resumes at 3.
4. CNT_W=8, GATE_CYCLES=100, i_clk[0]=250 MHz:
   - Counter wraps several times across windows.
   - o_count[0] = 250 ±1 mod 256 = 250 every window; modular subtract is correct across the wrap.
5. i_clk[3] stopped, others running -> o_count[3]=0, others correct.
6. rst asserted mid-window (async, off clock edge):
   - All outputs go to 0 immediately and o_seq=0.
   - After release, the sequence restarts from IDLE with a PRIME window before the first o_valid.
